wb_stage: RTL
=============

Name: wb_stage

Overview:
- Write-back end of the ARM pipeline; drives the register-file write port of the decode stage (Dest_wb, Result_WB, writeBackEn).
- Contains the MEM/WB pipeline register and selects the ALU result or the load data.
- Holds loads until a multi-cycle data memory returns read data; freezes upstream via wb_ready.

Parameters:
DATA_W, 32, data path width
REG_W, 4, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
mem_valid  in  1  MEM stage presents an instruction this cycle
mem_wb_en  in  1  instruction writes a register
mem_r_en  in  1  instruction is a load
mem_dest  in  REG_W  destination register index
alu_result  in  DATA_W  ALU result / address
mem_rdata  in  DATA_W  load data from data memory
mem_rdata_valid  in  1  mem_rdata valid this cycle (one-cycle strobe)
wb_ready  out  1  stage accepts an instruction; 0 = freeze MEM and earlier
Dest_wb  out  REG_W  register-file write index
Result_WB  out  DATA_W  register-file write data
writeBackEn  out  1  register-file write strobe

Behaviour:
- Reset (async, rst=1): state IDLE; Dest_wb=0, Result_WB=0, writeBackEn=0; internal pipeline register cleared. wb_ready=1 once rst is released.
- States: IDLE and LOAD_WAIT. wb_ready=1 in IDLE and 0 in LOAD_WAIT (combinational from state).
- Accept: mem_valid=1 and wb_ready=1 at a rising edge.
- Non-load accept (mem_r_en=0):
  - next cycle writeBackEn=mem_wb_en, Dest_wb=mem_dest, Result_WB=alu_result (1-cycle latency);
  - state stays IDLE.
- Load accept (mem_r_en=1):
  - capture mem_dest and mem_wb_en; writeBackEn=0 next cycle; state goes to LOAD_WAIT.
- In LOAD_WAIT, mem_rdata_valid=1 at an edge:
  - next cycle writeBackEn=captured wb_en, Dest_wb=captured dest, Result_WB=mem_rdata;
  - state goes to IDLE, so wb_ready=1 in that same cycle.
- Load with mem_wb_en=0: still waits for data; writes nothing.
- writeBackEn is a one-cycle pulse per retired writing instruction. It is 0 in every cycle with no retirement: bubbles (mem_valid=0), stores, branches, and LOAD_WAIT cycles.
- Memory contract: load data arrives no earlier than the cycle after acceptance. mem_rdata_valid in IDLE is ignored.
- mem_valid while wb_ready=0: ignored (upstream holds). Accept is re-evaluated every cycle.
- Back-to-back: a new instruction accepted in the cycle writeBackEn is high retires normally on the next edge, with no gap.
- Reset mid-LOAD_WAIT: pending load is dropped; no write is issued after reset.
- No arithmetic; widths pass through unchanged. Dest_wb and Result_WB hold their last values while writeBackEn=0.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - adds output port retire_cnt (32 bits);
  - counts cycles with writeBackEn=1 plus retired non-writing instructions (stores, branches, loads with wb_en=0);
  - wraps 0xFFFFFFFF to 0; cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then mem_valid=1, mem_wb_en=1, mem_r_en=0, mem_dest=3, alu_result=0x12 -> next cycle writeBackEn=1, Dest_wb=3, Result_WB=0x12; following cycle writeBackEn=0.
- Load, mem_dest=5; mem_rdata_valid asserted 3 cycles later with mem_rdata=0xDEADBEEF -> wb_ready=0 for 3 cycles, then writeBackEn=1, Dest_wb=5, Result_WB=0xDEADBEEF, wb_ready=1.
- Store (mem_wb_en=0, mem_r_en=0) followed by bubble -> writeBackEn stays 0, wb_ready stays 1.
- mem_valid held high with new instruction during LOAD_WAIT -> instruction not accepted until the cycle wb_ready returns to 1, then retires 1 cycle later.
- rst asserted mid-LOAD_WAIT, then mem_rdata_valid pulsed -> outputs 0 immediately, no writeBackEn pulse, state IDLE.
- WB_RETIRE_CNT_EN: counter preset near wrap (force 0xFFFFFFFF), retire two ALU instructions -> retire_cnt 0x0 then 0x1.

Source files
------------

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage : ARM write-back stage (MEM/WB register, ALU/load select, load hold)
// Optional: WB_RETIRE_CNT_EN adds a 32-bit retire counter.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_wb_en,
  input  logic              mem_r_en,
  input  logic [REG_W-1:0]  mem_dest,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic              wb_ready,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]       retire_cnt,
`endif
  output logic [REG_W-1:0]  Dest_wb,
  output logic [DATA_W-1:0] Result_WB,
  output logic              writeBackEn
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [REG_W-1:0]    dest_q, dest_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                wben_q, wben_d;
  logic [REG_W-1:0]    ld_dest_q, ld_dest_d;
  logic                ld_wben_q, ld_wben_d;
  logic                retire;

  assign wb_ready    = (state_q == IDLE);
  assign Dest_wb     = dest_q;
  assign Result_WB   = result_q;
  assign writeBackEn = wben_q;

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    result_d  = result_q;
    wben_d    = 1'b0;
    ld_dest_d = ld_dest_q;
    ld_wben_d = ld_wben_q;
    retire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (mem_r_en) begin
            ld_dest_d = mem_dest;
            ld_wben_d = mem_wb_en;
            state_d   = LOAD_WAIT;
          end else begin
            retire = 1'b1;
            wben_d = mem_wb_en;
            // Destination/data only move on a real write so they hold otherwise
            if (mem_wb_en) begin
              dest_d   = mem_dest;
              result_d = alu_result;
            end
          end
        end
      end
      LOAD_WAIT: begin
        if (mem_rdata_valid) begin
          retire  = 1'b1;
          wben_d  = ld_wben_q;
          state_d = IDLE;
          if (ld_wben_q) begin
            dest_d   = ld_dest_q;
            result_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dest_q    <= '0;
      result_q  <= '0;
      wben_q    <= 1'b0;
      ld_dest_q <= '0;
      ld_wben_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      result_q  <= result_d;
      wben_q    <= wben_d;
      ld_dest_q <= ld_dest_d;
      ld_wben_q <= ld_wben_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign retire_cnt = cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

`default_nettype wire
